// File: rtl/udma_eth_pkg.sv
// udma_eth_pkg: shared encodings, FSM states and defaults for the ethernet tx serializer
package udma_eth_pkg;
  localparam logic [1:0] TSIZE_1B = 2'h0;
  localparam logic [1:0] TSIZE_4B = 2'h3;
  localparam int MIN_FRAME_DEF = 60;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PAD} tx_state_e;
endpackage

// File: rtl/udma_eth_tx_serializer_if.sv
// udma_eth_tx_serializer_if: 32-bit word stream in, 8-bit byte stream out
// s_axis_*: words from the tx controller (tdata, tsize, tvalid, tuser, tlast in; tready out)
// m_axis_*: bytes toward the MAC (tdata, tvalid, tuser, tlast out; tready in)
// slave modport is the serializer side, master modport is the surrounding environment
interface udma_eth_tx_serializer_if;
  logic [31:0] s_axis_tdata_i;
  logic [1:0]  s_axis_tsize_i;
  logic        s_axis_tvalid_i;
  logic        s_axis_tuser_i;
  logic        s_axis_tlast_i;
  logic        s_axis_tready_o;
  logic [7:0]  m_axis_tdata_o;
  logic        m_axis_tvalid_o;
  logic        m_axis_tuser_o;
  logic        m_axis_tlast_o;
  logic        m_axis_tready_i;
  modport slave (
    input  s_axis_tdata_i, s_axis_tsize_i, s_axis_tvalid_i, s_axis_tuser_i, s_axis_tlast_i, m_axis_tready_i,
    output s_axis_tready_o, m_axis_tdata_o, m_axis_tvalid_o, m_axis_tuser_o, m_axis_tlast_o
  );
  modport master (
    output s_axis_tdata_i, s_axis_tsize_i, s_axis_tvalid_i, s_axis_tuser_i, s_axis_tlast_i, m_axis_tready_i,
    input  s_axis_tready_o, m_axis_tdata_o, m_axis_tvalid_o, m_axis_tuser_o, m_axis_tlast_o
  );
endinterface

// File: rtl/udma_eth_tx_serializer.sv
// udma_eth_tx_serializer: splits 32-bit words into MAC bytes, pads short frames, reports length/errors
// clk_i, rstn_i   : clock, asynchronous active-low reset
// bus             : word input stream and byte output stream (slave modport)
// frame_done_o    : one-cycle pulse after the last byte of a frame is accepted
// frame_len_o     : byte count of the last completed frame, padding included
// err_o           : one-cycle pulse on a misplaced tuser / missing tuser
module udma_eth_tx_serializer
  import udma_eth_pkg::*;
#(
  parameter int MIN_FRAME = MIN_FRAME_DEF,
  parameter bit PAD_EN    = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  udma_eth_tx_serializer_if.slave bus,
  output logic                   frame_done_o,
  output logic [15:0]            frame_len_o,
  output logic                   err_o
);
  tx_state_e   r_state, w_next;
  logic [31:0] r_data;
  logic [1:0]  r_tsize, r_idx;
  logic        r_tuser, r_tlast, r_open;
  logic [15:0] r_cnt, w_cnt_inc;
  logic        w_shift, w_pad_st, w_end_byte, w_pad, w_mhs, w_end, w_acc, w_start, w_fin;
  assign w_shift    = r_state == ST_SHIFT;
  assign w_pad_st   = r_state == ST_PAD;
  assign w_end_byte = w_shift && r_idx == r_tsize;
  // count as it will be once the byte on the bus is accepted, saturating
  assign w_cnt_inc  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_pad      = PAD_EN && int'(w_cnt_inc) < MIN_FRAME;
  assign bus.m_axis_tvalid_o = r_state != ST_IDLE;
  assign bus.m_axis_tdata_o  = w_shift ? r_data[{r_idx, 3'b000} +: 8] : 8'h00;
  assign bus.m_axis_tuser_o  = w_shift && r_tuser && r_idx == 2'd0;
  // PAD is only entered with padding enabled, so !w_pad there means the final pad byte
  assign bus.m_axis_tlast_o  = ((w_end_byte && r_tlast) || w_pad_st) && !w_pad;
  assign w_mhs   = bus.m_axis_tvalid_o && bus.m_axis_tready_i;
  assign w_end   = w_mhs && w_end_byte;
  // refill in the same cycle the last byte of a non-final word leaves: no bubble between words
  assign bus.s_axis_tready_o = r_state == ST_IDLE || (w_end && !r_tlast);
  assign w_acc   = bus.s_axis_tvalid_i && bus.s_axis_tready_o;
  assign w_start = w_acc && (bus.s_axis_tuser_i || !r_open);
  assign w_fin   = w_mhs && bus.m_axis_tlast_o;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = w_acc ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: w_next = !w_end ? ST_SHIFT : r_tlast ? (w_pad ? ST_PAD : ST_IDLE) : (w_acc ? ST_SHIFT : ST_IDLE);
      ST_PAD:   w_next = w_fin ? ST_IDLE : ST_PAD;
      default:  w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= ST_IDLE;
      r_data       <= '0;
      r_tsize      <= '0;
      r_tuser      <= 1'b0;
      r_tlast      <= 1'b0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_open       <= 1'b0;
      frame_done_o <= 1'b0;
      frame_len_o  <= '0;
      err_o        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_data  <= bus.s_axis_tdata_i;
        r_tsize <= bus.s_axis_tsize_i;
        r_tuser <= bus.s_axis_tuser_i;
        r_tlast <= bus.s_axis_tlast_i;
      end
      r_idx        <= w_acc ? 2'd0 : (w_mhs && w_shift) ? r_idx + 2'd1 : r_idx;
      r_cnt        <= w_start ? 16'd0 : w_mhs ? w_cnt_inc : r_cnt;
      r_open       <= w_acc ? 1'b1 : w_fin ? 1'b0 : r_open;
      frame_done_o <= w_fin;
      frame_len_o  <= w_fin ? w_cnt_inc : frame_len_o;
      // tuser while open, or no tuser while closed
      err_o        <= w_acc && (bus.s_axis_tuser_i == r_open);
    end
  end
endmodule

// File: doc/udma_eth_tx_serializer.md
UDMA_ETH_TX_SERIALIZER -- requirements
Module: udma_eth_tx_serializer

Interface
REQ-001 Parameter MIN_FRAME, default 60, minimum frame length in bytes after padding; legal range 1..65535.
REQ-002 Parameter PAD_EN, default 1, 1 = pad short frames with 0x00 up to MIN_FRAME, 0 = no padding.
REQ-003 clk_i  in  1  clock; all logic on rising edge.
REQ-004 rstn_i  in  1  reset, asynchronous, active-low.
REQ-005 s_axis_tdata_i  in  32  word from tx controller; byte 0 = [7:0].
REQ-006 s_axis_tsize_i  in  2  valid bytes in word minus one (0 = 1 byte, 3 = 4 bytes); byte k is valid for k <= tsize.
REQ-007 s_axis_tvalid_i / s_axis_tuser_i / s_axis_tlast_i  in  1 each  word valid / first word of frame / last word of frame.
REQ-008 s_axis_tready_o  out  1  word accepted when tvalid and tready are both high.
REQ-009 m_axis_tdata_o  out  8  byte toward MAC.
REQ-010 m_axis_tvalid_o / m_axis_tuser_o / m_axis_tlast_o  out  1 each  byte valid / first byte of frame / last byte of frame.
REQ-011 m_axis_tready_i  in  1  MAC accepts byte.
REQ-012 frame_done_o  out  1  one-cycle pulse when the last byte of a frame is accepted.
REQ-013 frame_len_o  out  16  bytes sent in the last completed frame, padding included; holds until the next frame completes.
REQ-014 err_o  out  1  one-cycle pulse on protocol error (REQ-024).

Function
REQ-015 FSM states: IDLE (buffer empty), SHIFT (emitting buffered bytes), PAD (emitting zero padding).
REQ-016 On an accepted word: latch data, tsize, tuser and tlast; clear byte index to 0; go to SHIFT.
REQ-017 SHIFT: m_axis_tvalid_o = 1 and m_axis_tdata_o = buffered byte[index]; the index increments on each m_axis handshake.
REQ-018 m_axis_tuser_o = 1 only on byte 0 of a word latched with tuser = 1.
REQ-019 Acceptance of byte index == tsize ends the word. If tlast = 0, go to IDLE, or stay in SHIFT when a new word is accepted in the same cycle. If tlast = 1 and padding is required, go to PAD; otherwise go to IDLE.
REQ-020 s_axis_tready_o = 1 in IDLE, and in SHIFT when the final byte of a non-tlast word is being accepted this cycle. This gives zero-bubble back-to-back words. s_axis_tready_o = 0 in PAD.
REQ-021 The frame byte counter is 16 bits. It resets to 0 at frame start and increments on every m_axis handshake, including pad bytes. It saturates at 0xFFFF.
REQ-022 Padding is required when PAD_EN = 1 and count after the final data byte < MIN_FRAME. PAD emits 0x00 until count = MIN_FRAME. m_axis_tlast_o is asserted on the final pad byte only.
REQ-023 Without padding, m_axis_tlast_o is asserted on byte index == tsize of the tlast word.
REQ-024 Error cases:
  - A tuser word accepted while a frame is open (no tlast seen yet): err_o pulses, the counter restarts, and the new frame proceeds.
  - A non-tuser word accepted with no frame open: err_o pulses and the word is transmitted as a new frame.
REQ-025 On frame completion: frame_done_o pulses in the cycle after the final handshake, and frame_len_o is updated in the same cycle.
REQ-026 When m_axis_tready_i = 0, all m_axis outputs, the index and the counter hold stable. Valid is never withdrawn once asserted.
REQ-027 tsize = 0 words take one output byte, allowing single-byte remainder transfers after word transfers.

Reset
REQ-028 Under reset: state = IDLE; s_axis_tready_o = 1; m_axis_tvalid/tuser/tlast = 0; m_axis_tdata_o = 0; frame_done_o = 0; err_o = 0; frame_len_o = 0; counter = 0; frame-open flag = 0.
REQ-029 Reset mid-frame discards the buffered word and any pending padding. No tlast is generated for the aborted frame.

Structure
REQ-030 Package udma_eth_pkg holds:
  - tsize encodings (TSIZE_1B = 2'h0, TSIZE_4B = 2'h3);
  - the FSM state enum;
  - the default MIN_FRAME constant (60).
REQ-031 The block is a single module with no sub-module. The counter, buffer and FSM are local.

Verification
REQ-032 One 64-byte frame (16 words, tsize 3, tuser on first word, tlast on last), m_axis_tready_i = 1 -> 64 bytes in order, with no bubble between words. tuser is on byte 0 only, tlast is on byte 63, frame_len_o = 64, and one frame_done_o pulse.
REQ-033 A 10-byte frame (2 words tsize 3 + 2 words tsize 0) with PAD_EN = 1 -> 10 data bytes, then 50 bytes of 0x00. tlast is on byte 59, s_axis_tready_o = 0 during PAD, and frame_len_o = 60.
REQ-034 The same 10-byte frame with PAD_EN = 0 -> tlast on byte 9 and frame_len_o = 10.
REQ-035 Random m_axis_tready_i (50%) over a 100-byte frame -> byte sequence identical to the zero-backpressure run, with outputs stable while stalled.
REQ-036 A tuser word arriving at byte 20 of an open frame -> one err_o pulse, a new frame begins, and the counter restarts at 0.
REQ-037 rstn_i asserted at byte 5 of a frame -> all outputs return to reset values immediately. A frame after release is sent intact with frame_len_o correct.
